// File: rtl/posit_pkg.sv
// Shared constants for the posit32 (es=3) datapath: format parameters,
// field widths and the multiplier-core state encoding.
package posit_pkg;
   localparam int ES         = 3;
   localparam int USEED_LOG2 = 3;
   localparam int K_MAX      = 30;
   localparam int K_MIN      = -30;

   localparam int K_W     = 6;
   localparam int EXP_W   = 3;
   localparam int MANT_W  = 32;
   localparam int SCALE_W = 10;
   localparam int ACC_W   = 2 * MANT_W;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_MUL  = 3'd1;
   localparam logic [2:0] S_NORM = 3'd2;
   localparam logic [2:0] S_PACK = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   // 8*k + exp: exp is exactly USEED_LOG2 unsigned bits, so the scale is
   // k concatenated with exp, sign-extended to SCALE_W.
   function automatic logic signed [SCALE_W-1:0] scale_of(input logic [K_W-1:0] k,
                                                         input logic [EXP_W-1:0] e);
      return {k[K_W-1], k, e};
   endfunction
endpackage

// File: rtl/posit_mul_core_if.sv
// Handshake/field bundle between the two decoders, the multiplier core and
// the encoder.
//   master : operand/acknowledge driver side (decoders + encoder)
//   slave  : posit_mul_core
interface posit_mul_core_if import posit_pkg::*;;
   logic               a_done, b_done;
   logic               a_sign, b_sign;
   logic               a_zero, b_zero, a_nar, b_nar;
   logic [K_W-1:0]     a_k, b_k;
   logic [EXP_W-1:0]   a_exp, b_exp;
   logic [MANT_W-1:0]  a_mant, b_mant;
   logic               op_recieved;
   logic               recieved;
   logic               done;
   logic               sign, ZERO, NAR;
   logic [K_W-1:0]     k;
   logic [EXP_W-1:0]   exp_value;
   logic [MANT_W-1:0]  mantissa;
   logic               sat;

   modport master (
      output a_done, b_done, a_sign, b_sign, a_zero, b_zero, a_nar, b_nar,
             a_k, b_k, a_exp, b_exp, a_mant, b_mant, recieved,
      input  op_recieved, done, sign, ZERO, NAR, k, exp_value, mantissa, sat
   );
   modport slave (
      input  a_done, b_done, a_sign, b_sign, a_zero, b_zero, a_nar, b_nar,
             a_k, b_k, a_exp, b_exp, a_mant, b_mant, recieved,
      output op_recieved, done, sign, ZERO, NAR, k, exp_value, mantissa, sat
   );
endinterface

// File: rtl/posit_mant_mul_seq.sv
// Sequential shift-add mantissa multiplier, one multiplier bit per cycle.
//   clk, rst : clock, async active-low reset
//   start    : load a/b and clear the accumulator
//   a, b     : 32-bit mantissas
//   done     : high during the final accumulate cycle (the edge that ends
//              it leaves product complete)
//   product  : 64-bit accumulator
module posit_mant_mul_seq import posit_pkg::*; (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [MANT_W-1:0] a,
   input  logic [MANT_W-1:0] b,
   output logic              done,
   output logic [ACC_W-1:0]  product
);
   localparam int CNT_W = $clog2(MANT_W);

   logic [MANT_W-1:0] a_q, b_q;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q;
   logic              busy_q;
   logic [ACC_W-1:0]  a_ext;

   assign a_ext   = {{MANT_W{1'b0}}, a_q};
   assign acc_d   = acc_q + (b_q[cnt_q] ? (a_ext << cnt_q) : '0);
   assign done    = busy_q && (cnt_q == CNT_W'(MANT_W - 1));
   assign product = acc_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_q    <= '0;
         b_q    <= '0;
         acc_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else if (start) begin
         a_q    <= a;
         b_q    <= b;
         acc_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b1;
      end else if (busy_q) begin
         acc_q <= acc_d;
         cnt_q <= cnt_q + 1'b1;
         if (done) busy_q <= 1'b0;
      end
   end
endmodule

// File: rtl/posit_mul_core.sv
// Posit32 (es=3) multiplier on decoded fields: captures two operand field
// sets, multiplies mantissas over 32 cycles, normalises, clamps the regime
// to [-30,30] and presents the product fields until acknowledged.
//   clk, rst : clock, async active-low reset
//   bus      : posit_mul_core_if.slave (operands, op_recieved, result, recieved)
// Build option: POSIT_MUL_RNE_EN selects round-to-nearest-even in NORM;
// without it the mantissa is truncated. Latency is the same either way.
module posit_mul_core import posit_pkg::*; (
   input  logic             clk,
   input  logic             rst,
   posit_mul_core_if.slave  bus
);
   localparam logic signed [SCALE_W-1:0] KMAX_S = SCALE_W'(K_MAX);
   localparam logic signed [SCALE_W-1:0] KMIN_S = SCALE_W'(K_MIN);
   localparam logic [MANT_W-1:0]         ONE_M  = {1'b1, {(MANT_W-1){1'b0}}};

   logic [2:0]                  state_q, state_d;
   logic signed [SCALE_W-1:0]   scale_q, scale_d;
   logic                        rsign_q, rsign_d;
   logic                        snar_q, snar_d, szero_q, szero_d;
   logic [MANT_W-1:0]           mnorm_q, mnorm_d;
   logic                        op_q, op_d, done_q, done_d;
   logic                        o_sign_q, o_sign_d, o_zero_q, o_zero_d, o_nar_q, o_nar_d;
   logic [K_W-1:0]              o_k_q, o_k_d;
   logic [EXP_W-1:0]            o_exp_q, o_exp_d;
   logic [MANT_W-1:0]           o_mant_q, o_mant_d;
   logic                        o_sat_q, o_sat_d;

   logic                        capture, special, mul_start, mul_done;
   logic [ACC_W-1:0]            prod;
   logic                        top;
   logic [MANT_W-1:0]           m_norm;
   logic signed [SCALE_W-1:0]   s_norm, k_full;

   assign capture   = (state_q == S_IDLE) && bus.a_done && bus.b_done;
   assign special   = bus.a_nar | bus.b_nar | bus.a_zero | bus.b_zero;
   assign mul_start = capture && !special;

   posit_mant_mul_seq u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (bus.a_mant),
      .b       (bus.b_mant),
      .done    (mul_done),
      .product (prod)
   );

   // Product of two [1,2) mantissas is in [1,4): bit 63 or bit 62 leads.
   assign top = prod[ACC_W-1];

`ifdef POSIT_MUL_RNE_EN
   logic              guard, sticky, rnd_up;
   logic [MANT_W-1:0] m_trunc;
   logic [MANT_W:0]   m_inc;
   logic signed [SCALE_W-1:0] s_top;

   assign m_trunc = top ? prod[63:32] : prod[62:31];
   assign guard   = top ? prod[31] : prod[30];
   assign sticky  = top ? |prod[30:0] : |prod[29:0];
   assign rnd_up  = guard && (sticky || m_trunc[0]);
   assign m_inc   = {1'b0, m_trunc} + {{MANT_W{1'b0}}, rnd_up};
   assign s_top   = top ? scale_q + 10'sd1 : scale_q;

   // A carry out of bit 31 means the mantissa rounded up to 2.0.
   always_comb begin
      m_norm = m_inc[MANT_W-1:0];
      s_norm = s_top;
      if (m_inc[MANT_W]) begin
         m_norm = ONE_M;
         s_norm = s_top + 10'sd1;
      end
   end
`else
   logic unused_lo;
   assign unused_lo = ^prod[30:0];
   assign m_norm    = top ? prod[63:32] : prod[62:31];
   assign s_norm    = top ? scale_q + 10'sd1 : scale_q;
`endif

   assign k_full = scale_q >>> USEED_LOG2;

   always_comb begin
      state_d  = state_q;
      scale_d  = scale_q;
      rsign_d  = rsign_q;
      snar_d   = snar_q;
      szero_d  = szero_q;
      mnorm_d  = mnorm_q;
      op_d     = 1'b0;
      done_d   = done_q;
      o_sign_d = o_sign_q;
      o_zero_d = o_zero_q;
      o_nar_d  = o_nar_q;
      o_k_d    = o_k_q;
      o_exp_d  = o_exp_q;
      o_mant_d = o_mant_q;
      o_sat_d  = o_sat_q;
      case (state_q)
         S_IDLE: if (capture) begin
            op_d    = 1'b1;
            scale_d = scale_of(bus.a_k, bus.a_exp) + scale_of(bus.b_k, bus.b_exp);
            rsign_d = bus.a_sign ^ bus.b_sign;
            snar_d  = bus.a_nar | bus.b_nar;
            szero_d = !(bus.a_nar | bus.b_nar) && (bus.a_zero | bus.b_zero);
            state_d = special ? S_PACK : S_MUL;
         end
         S_MUL: if (mul_done) state_d = S_NORM;
         S_NORM: begin
            mnorm_d = m_norm;
            scale_d = s_norm;
            state_d = S_PACK;
         end
         S_PACK: begin
            o_nar_d  = snar_q;
            o_zero_d = szero_q;
            o_sat_d  = 1'b0;
            if (snar_q || szero_q) begin
               o_sign_d = 1'b0;
               o_k_d    = '0;
               o_exp_d  = '0;
               o_mant_d = '0;
            end else begin
               o_sign_d = rsign_q;
               o_k_d    = k_full[K_W-1:0];
               o_exp_d  = scale_q[EXP_W-1:0];
               o_mant_d = mnorm_q;
               if (k_full > KMAX_S) begin
                  o_k_d    = K_W'(K_MAX);
                  o_exp_d  = '0;
                  o_mant_d = ONE_M;
                  o_sat_d  = 1'b1;
               end else if (k_full < KMIN_S) begin
                  o_k_d    = K_W'(K_MIN);
                  o_exp_d  = '0;
                  o_mant_d = ONE_M;
                  o_sat_d  = 1'b1;
               end
            end
            done_d  = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: if (bus.recieved) begin
            done_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         scale_q  <= '0;
         rsign_q  <= 1'b0;
         snar_q   <= 1'b0;
         szero_q  <= 1'b0;
         mnorm_q  <= '0;
         op_q     <= 1'b0;
         done_q   <= 1'b0;
         o_sign_q <= 1'b0;
         o_zero_q <= 1'b0;
         o_nar_q  <= 1'b0;
         o_k_q    <= '0;
         o_exp_q  <= '0;
         o_mant_q <= '0;
         o_sat_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         scale_q  <= scale_d;
         rsign_q  <= rsign_d;
         snar_q   <= snar_d;
         szero_q  <= szero_d;
         mnorm_q  <= mnorm_d;
         op_q     <= op_d;
         done_q   <= done_d;
         o_sign_q <= o_sign_d;
         o_zero_q <= o_zero_d;
         o_nar_q  <= o_nar_d;
         o_k_q    <= o_k_d;
         o_exp_q  <= o_exp_d;
         o_mant_q <= o_mant_d;
         o_sat_q  <= o_sat_d;
      end
   end

   assign bus.op_recieved = op_q;
   assign bus.done        = done_q;
   assign bus.sign        = o_sign_q;
   assign bus.ZERO        = o_zero_q;
   assign bus.NAR         = o_nar_q;
   assign bus.k           = o_k_q;
   assign bus.exp_value   = o_exp_q;
   assign bus.mantissa    = o_mant_q;
   assign bus.sat         = o_sat_q;
endmodule

// File: tb/tb_posit_mul_core.sv
// Directed, table-driven bench for posit_mul_core: a vector table of
// operand fields and hand-computed result fields, plus sequences for
// reset-in-flight and long done hold.
module tb_posit_mul_core;
   import posit_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   posit_mul_core_if bus ();
   posit_mul_core dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      string       nm;
      logic        as, az, an;
      logic [5:0]  ak;
      logic [2:0]  ae;
      logic [31:0] am;
      logic        bs, bz, bn;
      logic [5:0]  bk;
      logic [2:0]  be;
      logic [31:0] bm;
      logic        es, ez, en;
      logic [5:0]  ek;
      logic [2:0]  ee;
      logic [31:0] em;
      logic        esat;
      int          lat;
   } vec_t;

   int errors = 0;
   int checks = 0;
   vec_t vecs[13];

   function automatic vec_t mk(input string nm,
         input logic as, az, an, input logic [5:0] ak, input logic [2:0] ae, input logic [31:0] am,
         input logic bs, bz, bn, input logic [5:0] bk, input logic [2:0] be, input logic [31:0] bm,
         input logic es, ez, en, input logic [5:0] ek, input logic [2:0] ee, input logic [31:0] em,
         input logic esat, input int lat);
      vec_t v;
      v.nm = nm; v.as = as; v.az = az; v.an = an; v.ak = ak; v.ae = ae; v.am = am;
      v.bs = bs; v.bz = bz; v.bn = bn; v.bk = bk; v.be = be; v.bm = bm;
      v.es = es; v.ez = ez; v.en = en; v.ek = ek; v.ee = ee; v.em = em;
      v.esat = esat; v.lat = lat;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int hold);
      int lat = 0;
      int ops = 0;
      @(negedge clk);
      bus.a_sign = v.as; bus.a_zero = v.az; bus.a_nar = v.an;
      bus.a_k = v.ak; bus.a_exp = v.ae; bus.a_mant = v.am;
      bus.b_sign = v.bs; bus.b_zero = v.bz; bus.b_nar = v.bn;
      bus.b_k = v.bk; bus.b_exp = v.be; bus.b_mant = v.bm;
      bus.a_done = 1'b1; bus.b_done = 1'b1;
      @(posedge clk);               // capture edge
      @(negedge clk);
      if (bus.op_recieved) ops++;
      // operands stay valid throughout; op_recieved must still pulse once
      while (!bus.done && lat < 100) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (bus.op_recieved) ops++;
      end
      chk({v.nm, ".latency"}, lat, v.lat);
      chk({v.nm, ".op_pulses"}, ops, 1);
      chk({v.nm, ".sign"}, {31'd0, bus.sign}, {31'd0, v.es});
      chk({v.nm, ".ZERO"}, {31'd0, bus.ZERO}, {31'd0, v.ez});
      chk({v.nm, ".NAR"}, {31'd0, bus.NAR}, {31'd0, v.en});
      chk({v.nm, ".k"}, {26'd0, bus.k}, {26'd0, v.ek});
      chk({v.nm, ".exp"}, {29'd0, bus.exp_value}, {29'd0, v.ee});
      chk({v.nm, ".mant"}, bus.mantissa, v.em);
      chk({v.nm, ".sat"}, {31'd0, bus.sat}, {31'd0, v.esat});
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({v.nm, ".hold_done"}, {31'd0, bus.done}, 32'd1);
         chk({v.nm, ".hold_mant"}, bus.mantissa, v.em);
      end
      bus.a_done = 1'b0; bus.b_done = 1'b0;
      bus.recieved = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.recieved = 1'b0;
      chk({v.nm, ".done_cleared"}, {31'd0, bus.done}, 32'd0);
   endtask

   initial begin
      int seen;
      vecs[0]  = mk("one_x_one",   0,0,0, 6'h00,3'd0,32'h80000000, 0,0,0, 6'h00,3'd0,32'h80000000,
                                   0,0,0, 6'h00,3'd0,32'h80000000, 0, 34);
      vecs[1]  = mk("1p5_x_1p5",   0,0,0, 6'h00,3'd0,32'hC0000000, 0,0,0, 6'h00,3'd0,32'hC0000000,
                                   0,0,0, 6'h00,3'd1,32'h90000000, 0, 34);
      vecs[2]  = mk("exp_carry",   0,0,0, 6'h00,3'd7,32'h80000000, 0,0,0, 6'h00,3'd1,32'h80000000,
                                   0,0,0, 6'h01,3'd0,32'h80000000, 0, 34);
      vecs[3]  = mk("neg_k",       1,0,0, 6'h3F,3'd0,32'h80000000, 0,0,0, 6'h00,3'd0,32'h80000000,
                                   1,0,0, 6'h3F,3'd0,32'h80000000, 0, 34);
      vecs[4]  = mk("norm_carry",  0,0,0, 6'h00,3'd7,32'hC0000000, 1,0,0, 6'h00,3'd0,32'hC0000000,
                                   1,0,0, 6'h01,3'd0,32'h90000000, 0, 34);
      vecs[5]  = mk("neg_scale",   0,0,0, 6'h3F,3'd3,32'h80000000, 0,0,0, 6'h00,3'd2,32'h80000000,
                                   0,0,0, 6'h3F,3'd5,32'h80000000, 0, 34);
      vecs[6]  = mk("nar_zero",    1,0,1, 6'h05,3'd2,32'h80000000, 0,1,0, 6'h00,3'd0,32'h80000000,
                                   0,0,1, 6'h00,3'd0,32'h00000000, 0, 1);
      vecs[7]  = mk("zero_only",   1,1,0, 6'h00,3'd0,32'h80000000, 0,0,0, 6'h05,3'd3,32'hC0000000,
                                   0,1,0, 6'h00,3'd0,32'h00000000, 0, 1);
      vecs[8]  = mk("sat_hi",      0,0,0, 6'h1E,3'd0,32'h80000000, 0,0,0, 6'h1E,3'd0,32'h80000000,
                                   0,0,0, 6'h1E,3'd0,32'h80000000, 1, 34);
      vecs[9]  = mk("sat_lo",      0,0,0, 6'h22,3'd0,32'h80000000, 0,0,0, 6'h22,3'd0,32'h80000000,
                                   0,0,0, 6'h22,3'd0,32'h80000000, 1, 34);
      vecs[10] = mk("k30_nosat",   0,0,0, 6'h0F,3'd0,32'h80000000, 0,0,0, 6'h0F,3'd7,32'h80000000,
                                   0,0,0, 6'h1E,3'd7,32'h80000000, 0, 34);
      vecs[11] = mk("k31_sat",     0,0,0, 6'h0F,3'd7,32'hC0000000, 0,0,0, 6'h0F,3'd1,32'h80000000,
                                   0,0,0, 6'h1E,3'd0,32'h80000000, 1, 34);
`ifdef POSIT_MUL_RNE_EN
      vecs[12] = mk("guard_bit",   0,0,0, 6'h00,3'd0,32'h80000001, 0,0,0, 6'h00,3'd0,32'hC0000000,
                                   0,0,0, 6'h00,3'd0,32'hC0000002, 0, 34);
`else
      vecs[12] = mk("guard_bit",   0,0,0, 6'h00,3'd0,32'h80000001, 0,0,0, 6'h00,3'd0,32'hC0000000,
                                   0,0,0, 6'h00,3'd0,32'hC0000001, 0, 34);
`endif

      bus.a_done = 0; bus.b_done = 0; bus.recieved = 0;
      bus.a_sign = 0; bus.a_zero = 0; bus.a_nar = 0; bus.a_k = '0; bus.a_exp = '0; bus.a_mant = '0;
      bus.b_sign = 0; bus.b_zero = 0; bus.b_nar = 0; bus.b_k = '0; bus.b_exp = '0; bus.b_mant = '0;

      repeat (3) @(negedge clk);
      chk("reset.done", {31'd0, bus.done}, 32'd0);
      chk("reset.op_recieved", {31'd0, bus.op_recieved}, 32'd0);
      chk("reset.k_mant_sat", {bus.mantissa[31:7], bus.k, bus.sat}, 32'd0);
      rst = 1'b1;

      for (int i = 0; i < 13; i++) run_vec(vecs[i], (i == 1) ? 20 : 0);

      // Reset part-way through MUL aborts the product.
      @(negedge clk);
      bus.a_k = '0; bus.a_exp = '0; bus.a_mant = 32'h80000000; bus.a_sign = 0;
      bus.b_k = '0; bus.b_exp = '0; bus.b_mant = 32'h80000000; bus.b_sign = 1;
      bus.a_zero = 0; bus.a_nar = 0; bus.b_zero = 0; bus.b_nar = 0;
      bus.a_done = 1; bus.b_done = 1;
      @(posedge clk);
      repeat (10) @(posedge clk);
      @(negedge clk);
      bus.a_done = 0; bus.b_done = 0;
      rst = 1'b0;
      #1;
      chk("abort.done", {31'd0, bus.done}, 32'd0);
      chk("abort.op_recieved", {31'd0, bus.op_recieved}, 32'd0);
      chk("abort.flags", {28'd0, bus.sign, bus.ZERO, bus.NAR, bus.sat}, 32'd0);
      chk("abort.k_exp", {23'd0, bus.k, bus.exp_value}, 32'd0);
      chk("abort.mant", bus.mantissa, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) seen++;
      end
      chk("abort.no_done", seen, 0);
      run_vec(vecs[0], 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
